// File: rtl/mul_div_issue_queue.sv
// In-order issue queue for the mul/div unit: buffers dispatched op pairs, snoops
// result wakeups for four source operands each, and presents only the oldest entry.
module mul_div_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 128,
  parameter int NWAKE     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [PAYLOAD_W-1:0]    disp_payload,
  input  logic [4*PREG_W-1:0]     disp_tag,
  input  logic [3:0]              disp_rdy,
  input  logic [NWAKE-1:0]        wake_valid,
  input  logic [NWAKE*PREG_W-1:0] wake_tag,
  output logic                    issue_valid,
  output logic [PAYLOAD_W-1:0]    issue_payload,
  input  logic                    md_allowin,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PREG_W-1:0]    tag_q     [DEPTH][4];
  logic [3:0]           rdy_q     [DEPTH];
  logic [PTR_W-1:0]     head, tail;

  logic [3:0] wake_hit [DEPTH];
  logic [3:0] disp_rdy_w;
  logic       push, pop;

  function automatic logic woken(input logic [PREG_W-1:0]       t,
                                 input logic [NWAKE-1:0]        v,
                                 input logic [NWAKE*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NWAKE; k++)
      if (v[k] && (wt[k*PREG_W +: PREG_W] == t)) hit = 1'b1;
    return hit;
  endfunction

  // Wakeup match: stored entries and the incoming dispatch are compared in the same cycle
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wake_hit[e] = 4'b0000;
      for (int i = 0; i < 4; i++)
        wake_hit[e][i] = woken(tag_q[e][i], wake_valid, wake_tag);
    end
    disp_rdy_w = disp_rdy;
    for (int i = 0; i < 4; i++)
      if (woken(disp_tag[i*PREG_W +: PREG_W], wake_valid, wake_tag)) disp_rdy_w[i] = 1'b1;
  end

  assign disp_ready    = (count < FULL);
  assign issue_valid   = (count != '0) && (&rdy_q[head]) && !flush && !reset;
  assign issue_payload = payload_q[head];
  assign push          = disp_valid && disp_ready && !flush;
  assign pop           = issue_valid && md_allowin;

  // Control state: pointers, occupancy and ready bits
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) rdy_q[e] <= 4'b0000;
    end else begin
      // Stale bits in free slots are harmless: a push overwrites the whole ready vector.
      for (int e = 0; e < DEPTH; e++) rdy_q[e] <= rdy_q[e] | wake_hit[e];
      if (push) begin
        rdy_q[tail] <= disp_rdy_w;
        tail        <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data storage, written only on push and never reset
  always_ff @(posedge clk) begin
    if (push) begin
      payload_q[tail] <= disp_payload;
      for (int i = 0; i < 4; i++) tag_q[tail][i] <= disp_tag[i*PREG_W +: PREG_W];
    end
  end

endmodule

// File: tb/tb_mul_div_issue_queue.sv
// Bench for mul_div_issue_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_mul_div_issue_queue;
  localparam int DEPTH = 4;
  localparam int PW    = 6;
  localparam int PLW   = 128;
  localparam int NW    = 4;

  logic             clk = 1'b0;
  logic             reset, flush, disp_valid, disp_ready, issue_valid, md_allowin;
  logic [PLW-1:0]   disp_payload, issue_payload;
  logic [4*PW-1:0]  disp_tag;
  logic [3:0]       disp_rdy;
  logic [NW-1:0]    wake_valid;
  logic [NW*PW-1:0] wake_tag;
  logic [2:0]       count;

  mul_div_issue_queue #(.DEPTH(DEPTH), .PREG_W(PW), .PAYLOAD_W(PLW), .NWAKE(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
    .disp_tag(disp_tag), .disp_rdy(disp_rdy),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .issue_valid(issue_valid), .issue_payload(issue_payload),
    .md_allowin(md_allowin), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PLW-1:0]  pl;
    logic [4*PW-1:0] tg;
    logic [3:0]      rd;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seq   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic woke(input logic [PW-1:0] t);
    for (int k = 0; k < NW; k++)
      if (wake_valid[k] && wake_tag[k*PW +: PW] == t) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    logic exp_iv;
    ent_t e;
    #2;
    exp_iv = (q.size() > 0) && (&q[0].rd) && !flush && !reset;
    check("count", 128'(count), 128'(q.size()));
    check("disp_ready", 128'(disp_ready), 128'(q.size() < DEPTH));
    check("issue_valid", 128'(issue_valid), 128'(exp_iv));
    if (q.size() > 0) check("issue_payload", issue_payload, q[0].pl);
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
    end else begin
      logic do_push;
      do_push = disp_valid && (q.size() < DEPTH);
      for (int j = 0; j < q.size(); j++) begin
        e = q[j];
        for (int i = 0; i < 4; i++) if (woke(e.tg[i*PW +: PW])) e.rd[i] = 1'b1;
        q[j] = e;
      end
      if (exp_iv && md_allowin) void'(q.pop_front());
      if (do_push) begin
        e.pl = disp_payload;
        e.tg = disp_tag;
        e.rd = disp_rdy;
        for (int i = 0; i < 4; i++) if (woke(disp_tag[i*PW +: PW])) e.rd[i] = 1'b1;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic allow);
    reset = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_rdy = 4'b0000;
    disp_tag = '0; wake_valid = '0; wake_tag = '0; md_allowin = allow;
    disp_payload = '0;
  endtask

  task automatic offer(input logic [3:0] rdy, input logic [4*PW-1:0] tags);
    seq++;
    disp_valid   = 1'b1;
    disp_rdy     = rdy;
    disp_tag     = tags;
    disp_payload = {32'hA5A5_0000 + 32'(seq), $urandom, $urandom, 32'(seq)};
  endtask

  initial begin
    idle(1'b0);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    cycle();                      // reset state
    idle(1'b0); cycle();

    // Fully ready entry: issues next cycle, drains the cycle after.
    idle(1'b1); offer(4'b1111, 24'h0); cycle();
    idle(1'b1); cycle();
    idle(1'b1); cycle();

    // Pending src2 (tag 0x15) woken on port 2.
    idle(1'b1); offer(4'b1101, {6'd3, 6'd2, 6'h15, 6'd1}); cycle();
    idle(1'b1); cycle(); cycle();
    idle(1'b1); wake_valid[2] = 1'b1; wake_tag[2*PW +: PW] = 6'h15; cycle();
    idle(1'b1); cycle(); cycle();

    // Wake in the dispatch cycle for the LO slot.
    idle(1'b1); offer(4'b0111, {6'h22, 6'd0, 6'd0, 6'd0});
    wake_valid[0] = 1'b1; wake_tag[PW-1:0] = 6'h22; cycle();
    idle(1'b1); cycle(); cycle();

    // Fill under backpressure, extra offer ignored, drain in order, refill across the wrap.
    for (int n = 0; n < 5; n++) begin idle(1'b0); offer(4'b1111, 24'h0); cycle(); end
    idle(1'b0); cycle();
    for (int n = 0; n < 5; n++) begin idle(1'b1); cycle(); end
    for (int n = 0; n < 4; n++) begin idle(1'b0); offer(4'b1111, 24'h0); cycle(); end
    for (int n = 0; n < 5; n++) begin idle(1'b1); cycle(); end

    // Non-ready head (src1 tag 0x30) blocks a ready younger entry.
    idle(1'b1); offer(4'b1110, {6'd0, 6'd0, 6'd0, 6'h30}); cycle();
    idle(1'b1); offer(4'b1011, {6'd0, 6'h31, 6'd0, 6'd0}); cycle();
    idle(1'b1); offer(4'b1111, 24'h0); cycle();
    idle(1'b1); cycle(); cycle();
    idle(1'b1); wake_valid[3] = 1'b1; wake_tag[3*PW +: PW] = 6'h30; cycle();
    idle(1'b1); cycle();
    idle(1'b1); wake_valid[1] = 1'b1; wake_tag[PW +: PW] = 6'h31; cycle();
    for (int n = 0; n < 4; n++) begin idle(1'b1); cycle(); end

    // Flush with three queued entries and a simultaneous dispatch.
    for (int n = 0; n < 3; n++) begin idle(1'b0); offer(4'b1111, 24'h0); cycle(); end
    idle(1'b1); offer(4'b1111, 24'h0); flush = 1'b1; cycle();
    idle(1'b1); cycle(); cycle();

    // Random traffic with a small tag space so wakeups collide often.
    for (int n = 0; n < 3000; n++) begin
      idle($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 2) != 0) begin
        logic [4*PW-1:0] t;
        for (int i = 0; i < 4; i++) t[i*PW +: PW] = 6'($urandom_range(0, 7));
        offer(4'($urandom), t);
      end
      for (int k = 0; k < NW; k++) begin
        wake_valid[k]        = ($urandom_range(0, 3) == 0);
        wake_tag[k*PW +: PW] = 6'($urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
